i2s_dac_transmitter: RTL
========================

Name: i2s_dac_transmitter

Overview:
- I2S master transmitter, the playback-side counterpart of the INMP441 microphone receiver path.
- Generates BCLK and LRCLK from the system clock and serialises stereo PCM samples MSB-first onto SDATA for an external I2S DAC/amp (PCM5102, MAX98357 class).
- Accepts one left/right sample pair per frame through a valid/ready handshake into a single-entry holding register.
- Frame format: 64 BCLK per frame, two 32-bit slots, standard I2S one-BCLK data delay.

Parameters:
- SAMPLE_W, 24, bits per channel sample; legal range 8..31.
- BCLK_HALF, 16, clk cycles per BCLK half-period; must be ≥2. Default gives a 32-clk BCLK and a 2048-clk frame (31.7 kHz at 65 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_left  in  SAMPLE_W  left sample, two's complement
- sample_right  in  SAMPLE_W  right sample, two's complement
- sample_valid  in  1  source has a sample pair on sample_left/right
- sample_ready  out  1  holding register empty; pair accepted when valid&&ready at posedge clk
- bclk  out  1  I2S bit clock (registered)
- lrclk  out  1  I2S word select, 0=left, 1=right (registered)
- sdata  out  1  I2S serial data (registered)
- frame_start  out  1  one-clk pulse when a new frame's data is loaded
- underrun  out  1  one-clk pulse when a frame starts with no pending pair

Behaviour:
- Decided: reset is reset, asynchronous, active-high; clock is clk. All state is in the clk domain.
- Reset values:
  - half_cnt=0, bclk=0, bit_cnt=63, lrclk=1, sdata=0.
  - pending_full=0, so sample_ready=1.
  - active_left/right=0, frame_start=0, underrun=0.
- Divider: half_cnt counts 0..BCLK_HALF-1. On the clk where half_cnt==BCLK_HALF-1, half_cnt wraps to 0 and bclk toggles.
- Fall event: the clk where bclk toggles 1->0. All lrclk/sdata/bit_cnt updates happen only on fall events, registered in the same clk as the bclk edge. DAC samples on bclk rising.
- First fall event after reset release is at clk 2*BCLK_HALF.
- On each fall event:
  - bit_cnt <= bit_cnt+1 mod 64.
  - lrclk <= (new bit_cnt ≥ 32).
  - Slot position p = new bit_cnt mod 32.
- sdata per slot position:
  - p=0: 0 (I2S delay bit).
  - p=1..SAMPLE_W: channel sample bit [SAMPLE_W-p], MSB first.
  - p>SAMPLE_W: 0.
  - Channel is left when lrclk=0, right when lrclk=1.
- Frame boundary (fall event with bit_cnt 63->0):
  - If pending_full: active_left/right <= pending pair, pending_full <= 0, frame_start=1 for this clk.
  - Else: active <= 0 (silence), frame_start=1, underrun=1 for this clk.
  - The right slot of a frame always uses the pair loaded at that frame's boundary.
- Handshake:
  - sample_ready = ~pending_full (registered state only, no combinational path from sample_valid).
  - Accept: pending <= inputs, pending_full <= 1.
  - Source must hold data stable while valid && !ready.
- Simultaneous accept and boundary: possible only when pending_full=0.
  - The boundary loads silence and flags underrun.
  - The accepted pair lands in pending and plays next frame.
- Load/clear ordering: a boundary with pending_full=1 clears pending_full. sample_ready rises the following clk, so at most one accept per frame.
- Reset mid-operation: all state returns immediately to reset values; any pending pair is discarded. Outputs go to reset levels asynchronously.
- Throughput: exactly one pair consumed per 64*2*BCLK_HALF clks.

Test Plan:
- Reset:
  - Assert reset for 3 clks → bclk=0, lrclk=1, sdata=0, sample_ready=1, frame_start=0, underrun=0.
  - First bclk rise at clk BCLK_HALF after release; first fall/frame_start at clk 2*BCLK_HALF.
- Single pair (BCLK_HALF=2):
  - Present L=24'hA5F00F, R=24'h123456 before the first boundary → accepted; sample_ready=0 until the boundary clk+1.
  - BFM sampling on bclk rise captures left positions 1..24 = A5F00F, positions 0 and 25..31 = 0, then right = 123456.
  - One frame_start pulse, no underrun.
- Underrun: no valid for one frame → underrun and frame_start each pulse once at the boundary; all 64 sdata bits are 0.
- Streaming:
  - sample_valid held high with L=n, R=~n incrementing on accept, over 8 frames → exactly one accept per frame.
  - BFM output sequence equals the input sequence; no underrun after the first frame.
- Timing (defaults):
  - bclk period = 32 clk, lrclk period = 2048 clk with 50% duty.
  - lrclk/sdata transitions occur only on clks where bclk falls.
  - The lrclk edge precedes the MSB by one bclk.
- Reset mid-frame:
  - With pending_full=1 and bit_cnt=40, pulse reset → sample_ready=1 immediately.
  - Next frame outputs silence with underrun=1 (pending pair discarded).

Source files
------------

// File: rtl/i2s_dac_transmitter.sv
// I2S master transmitter: divides clk into BCLK/LRCLK and shifts stereo PCM out MSB-first
// with the standard one-BCLK data delay, 64 BCLK per frame, one sample pair per frame.
module i2s_dac_transmitter #(
  parameter int unsigned SAMPLE_W  = 24,
  parameter int unsigned BCLK_HALF = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_left,
  input  logic [SAMPLE_W-1:0] sample_right,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);

  localparam int unsigned CntW = $clog2(BCLK_HALF);
  localparam logic [CntW-1:0] HalfMax = CntW'(BCLK_HALF - 1);

  logic [CntW-1:0]     half_cnt_q;
  logic [5:0]          bit_cnt_q;
  logic                bclk_q, lrclk_q, sdata_q, frame_start_q, underrun_q;
  logic                pending_full_q;
  logic [SAMPLE_W-1:0] pend_left_q, pend_right_q, act_left_q, act_right_q;

  logic        half_wrap, fall, boundary, accept, sdata_nxt;
  logic [5:0]  bit_cnt_nxt;
  logic [4:0]  slot_pos;
  logic [31:0] slot_word;

  always_comb begin
    half_wrap   = (half_cnt_q == HalfMax);
    fall        = half_wrap && bclk_q;
    boundary    = fall && (bit_cnt_q == 6'd63);
    accept      = sample_valid && !pending_full_q;
    bit_cnt_nxt = bit_cnt_q + 6'd1;
    slot_pos    = bit_cnt_nxt[4:0];
    // Slot word has the sample MSB at bit 30 so slot position p maps to bit 31-p;
    // position 0 is the delay bit, so the pair swapped in at a boundary is never shifted early.
    slot_word   = 32'(bit_cnt_nxt[5] ? act_right_q : act_left_q) << (31 - SAMPLE_W);
    sdata_nxt   = (slot_pos != 5'd0) && slot_word[5'd31 - slot_pos];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt_q     <= '0;
      bclk_q         <= 1'b0;
      bit_cnt_q      <= 6'd63;
      lrclk_q        <= 1'b1;
      sdata_q        <= 1'b0;
      pending_full_q <= 1'b0;
      pend_left_q    <= '0;
      pend_right_q   <= '0;
      act_left_q     <= '0;
      act_right_q    <= '0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      half_cnt_q    <= half_wrap ? '0 : half_cnt_q + CntW'(1);
      if (half_wrap) bclk_q <= ~bclk_q;
      if (fall) begin
        bit_cnt_q <= bit_cnt_nxt;
        lrclk_q   <= bit_cnt_nxt[5];
        sdata_q   <= sdata_nxt;
      end
      if (boundary) begin
        frame_start_q <= 1'b1;
        if (pending_full_q) begin
          act_left_q     <= pend_left_q;
          act_right_q    <= pend_right_q;
          pending_full_q <= 1'b0;
        end else begin
          act_left_q  <= '0;
          act_right_q <= '0;
          underrun_q  <= 1'b1;
        end
      end
      // accept requires an empty holding register, so it never collides with the clear above
      if (accept) begin
        pend_left_q    <= sample_left;
        pend_right_q   <= sample_right;
        pending_full_q <= 1'b1;
      end
    end
  end

  assign sample_ready = ~pending_full_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule
